// File: rtl/hex_entry_pad.sv
// hex_entry_pad: five raw board buttons are synchronized and debounced, and
// their press pulses edit a 32-bit hex value one nibble at a time. up/down
// change the nibble under the cursor, left/right move the cursor, and center
// commits the working value to commit_data.
// Optional feature: define HEX_ENTRY_BLINK_EN to blink the digit under the
// cursor through blink_mask. Without it, blink_mask is tied low and no blink
// counter exists.
module hex_entry_pad #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF      = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [31:0] data_out,
  output logic [2:0]  cursor,
  output logic        commit,
  output logic [31:0] commit_data,
  output logic [7:0]  blink_mask
);

  localparam int NB       = 5;
  localparam int B_RIGHT  = 0;
  localparam int B_LEFT   = 1;
  localparam int B_DOWN   = 2;
  localparam int B_UP     = 3;
  localparam int B_CENTER = 4;

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {DB_S0, DB_W1, DB_S1, DB_W0} db_state_e;

  if (DEBOUNCE_CYCLES < 2 || BLINK_HALF < 1) begin : g_param_check
    $error("hex_entry_pad: DEBOUNCE_CYCLES must be >= 2 and BLINK_HALF >= 1");
  end

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] press;

  assign btn_raw = {btn_center, btn_up, btn_down, btn_left, btn_right};

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the previous sync1_q,
      // so there really are two flop stages.
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_db
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Debounce next state: count stable cycles while waiting; pulse on an accepted press.
    always_comb begin
      // NOTE: every output gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      unique case (state_q)
        DB_S0: begin
          if (sync2_q[b]) begin
            state_d = DB_W1;
            cnt_d   = '0;
          end
        end
        DB_W1: begin
          if (!sync2_q[b]) begin
            state_d = DB_S0;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = DB_S1;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DB_S1: begin
          if (!sync2_q[b]) begin
            state_d = DB_W0;
            cnt_d   = '0;
          end
        end
        DB_W0: begin
          if (sync2_q[b]) begin
            state_d = DB_S1;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = DB_S0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = DB_S0;
          cnt_d   = '0;
        end
      endcase
    end

    // Debounce state, stable-cycle counter and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= DB_S0;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    assign press[b] = press_q;
  end

  logic [31:0] data_q, data_d;
  logic [31:0] commit_data_q, commit_data_d;
  logic [2:0]  cursor_q, cursor_d;
  logic        commit_q, commit_d;
  logic [4:0]  nib_lsb;

  assign nib_lsb = {cursor_q, 2'b00};

  // Apply the highest-priority press pulse; lower-priority ones in the same cycle are dropped.
  always_comb begin
    data_d        = data_q;
    cursor_d      = cursor_q;
    commit_data_d = commit_data_q;
    commit_d      = 1'b0;
    if (press[B_CENTER]) begin
      commit_data_d = data_q;
      commit_d      = 1'b1;
    end else if (press[B_UP]) begin
      data_d[nib_lsb +: 4] = data_q[nib_lsb +: 4] + 4'd1;
    end else if (press[B_DOWN]) begin
      data_d[nib_lsb +: 4] = data_q[nib_lsb +: 4] - 4'd1;
    end else if (press[B_LEFT]) begin
      cursor_d = cursor_q + 3'd1;
    end else if (press[B_RIGHT]) begin
      cursor_d = cursor_q - 3'd1;
    end
  end

  // Working value, cursor, committed value and commit strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q        <= '0;
      cursor_q      <= '0;
      commit_data_q <= '0;
      commit_q      <= 1'b0;
    end else begin
      data_q        <= data_d;
      cursor_q      <= cursor_d;
      commit_data_q <= commit_data_d;
      commit_q      <= commit_d;
    end
  end

  assign data_out    = data_q;
  assign cursor      = cursor_q;
  assign commit      = commit_q;
  assign commit_data = commit_data_q;

`ifdef HEX_ENTRY_BLINK_EN
  localparam int            BW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          edit_act;

  // An accepted edit is any up/down/left/right pulse that center does not override.
  assign edit_act = ~press[B_CENTER] & (|press[B_UP:B_RIGHT]);

  // Free-running half-period counter; an edit restarts it in the visible phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (edit_act) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_mask = phase_q ? (8'h01 << cursor_q) : 8'h00;
`else
  assign blink_mask = 8'h00;
`endif

endmodule

// File: tb/tb_hex_entry_pad.sv
// Directed bench for hex_entry_pad with a scoreboard: every press pushes its
// expected result; a negedge monitor pops one entry per observed output
// change and also checks the raw-edge-to-output latency.
module tb_hex_entry_pad;

  localparam int DC = 4;
  localparam int BH = 8;

  localparam logic [4:0] M_RIGHT  = 5'b00001;
  localparam logic [4:0] M_LEFT   = 5'b00010;
  localparam logic [4:0] M_DOWN   = 5'b00100;
  localparam logic [4:0] M_UP     = 5'b01000;
  localparam logic [4:0] M_CENTER = 5'b10000;

  logic        clk;
  logic        rst_n;
  logic [4:0]  btn;
  logic [31:0] data_out;
  logic [2:0]  cursor;
  logic        commit;
  logic [31:0] commit_data;
  logic [7:0]  blink_mask;

  hex_entry_pad #(
    .DEBOUNCE_CYCLES(DC),
    .BLINK_HALF     (BH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up     (btn[3]),
    .btn_down   (btn[2]),
    .btn_left   (btn[1]),
    .btn_right  (btn[0]),
    .btn_center (btn[4]),
    .data_out   (data_out),
    .cursor     (cursor),
    .commit     (commit),
    .commit_data(commit_data),
    .blink_mask (blink_mask)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cur;
    logic        commit;
    logic [31:0] cdata;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] m_data;
  logic [31:0] m_cdata;
  logic [2:0]  m_cur;
  logic [31:0] prev_data;
  logic [2:0]  prev_cur;
  exp_t        mon_e;
  int          mon_lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Update the reference model for one press (highest priority wins) and queue the result.
  task automatic expect_press(input logic [4:0] mask);
    exp_t e;
    int   idx;
    idx      = 4 * int'(m_cur);
    e.commit = 1'b0;
    if (mask[4]) begin
      m_cdata  = m_data;
      e.commit = 1'b1;
    end else if (mask[3]) begin
      m_data[idx +: 4] = m_data[idx +: 4] + 4'd1;
    end else if (mask[2]) begin
      m_data[idx +: 4] = m_data[idx +: 4] - 4'd1;
    end else if (mask[1]) begin
      m_cur = m_cur + 3'd1;
    end else if (mask[0]) begin
      m_cur = m_cur - 3'd1;
    end
    e.data  = m_data;
    e.cur   = m_cur;
    e.cdata = m_cdata;
    e.t0    = cyc;
    sb.push_back(e);
  endtask

  task automatic press(input logic [4:0] mask, input int hold = 10, input int rel = 10);
    @(negedge clk);
    expect_press(mask);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = '0;
    repeat (rel) @(negedge clk);
  endtask

  // Monitor: any change of data_out/cursor, or a commit strobe, consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_data = data_out;
      prev_cur  = cursor;
    end else begin
      if (data_out !== prev_data || cursor !== prev_cur || commit !== 1'b0) begin
        if (sb.size() == 0) begin
          check("spurious_output_event_pending", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("ev_data", data_out, mon_e.data);
          check("ev_cursor", 32'(cursor), 32'(mon_e.cur));
          check("ev_commit", 32'(commit), 32'(mon_e.commit));
          check("ev_commit_data", commit_data, mon_e.cdata);
          // The raw change is captured by the first edge after it is driven.
          mon_lat = cyc - mon_e.t0 - 1;
          check("ev_latency_7pm1", 32'((mon_lat >= 6) && (mon_lat <= 8)), 32'd1);
        end
      end
      prev_data = data_out;
      prev_cur  = cursor;
`ifndef HEX_ENTRY_BLINK_EN
      check("blink_mask_tied_low", 32'(blink_mask), 32'd0);
`endif
    end
  end

`ifdef HEX_ENTRY_BLINK_EN
  logic [7:0] seen_mask;
  logic [7:0] first_mask;
  logic       found;
`endif

  initial begin
    rst_n   = 1'b1;
    btn     = '0;
    m_data  = '0;
    m_cdata = '0;
    m_cur   = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 32'h0);
    check("rst_cursor", 32'(cursor), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_commit_data", commit_data, 32'h0);
    check("rst_blink_mask", 32'(blink_mask), 32'd0);
    rst_n = 1'b1;

    repeat (50) @(negedge clk);
    check("idle_data_out", data_out, 32'h0);
    check("idle_cursor", 32'(cursor), 32'd0);
    check("idle_commit_data", commit_data, 32'h0);

    repeat (3) press(M_UP);
    check("up3_data", data_out, 32'h0000_0003);
    repeat (4) press(M_DOWN);
    check("down4_wrap_data", data_out, 32'h0000_000F);
    press(M_UP);
    check("up_wrap_no_carry", data_out, 32'h0000_0000);
    press(M_DOWN);
    check("down_back_to_f", data_out, 32'h0000_000F);

    repeat (9) press(M_LEFT);
    check("left9_cursor", 32'(cursor), 32'd1);
    press(M_UP);
    check("up_digit1_data", data_out, 32'h0000_001F);
    repeat (2) press(M_RIGHT);
    check("right2_wrap_cursor", 32'(cursor), 32'd7);

    // Glitches of two cycles must never be accepted.
    repeat (5) begin
      @(negedge clk);
      btn = M_UP;
      repeat (2) @(negedge clk);
      btn = '0;
      repeat (8) @(negedge clk);
    end
    check("glitch_no_change", data_out, 32'h0000_001F);

    press(M_UP, 200, 10);
    check("long_hold_one_inc", data_out, 32'h1000_001F);
    press(M_DOWN);
    check("down_digit7", data_out, 32'h0000_001F);

    press(M_UP | M_CENTER);
    check("prio_data_unchanged", data_out, 32'h0000_001F);
    check("prio_commit_data", commit_data, 32'h0000_001F);
    check("prio_cursor", 32'(cursor), 32'd7);

    // Reset while btn_up is part-way through its debounce window.
    @(negedge clk);
    btn = M_UP;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_data_out", data_out, 32'h0);
    check("midrst_cursor", 32'(cursor), 32'd0);
    check("midrst_commit", 32'(commit), 32'd0);
    check("midrst_commit_data", commit_data, 32'h0);
    check("midrst_blink_mask", 32'(blink_mask), 32'd0);
    btn = '0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_data  = '0;
    m_cdata = '0;
    m_cur   = '0;
    repeat (30) @(negedge clk);
    check("postrst_data_out", data_out, 32'h0);
    check("postrst_cursor", 32'(cursor), 32'd0);

    repeat (2) press(M_LEFT);
    check("blink_setup_cursor", 32'(cursor), 32'd2);

`ifdef HEX_ENTRY_BLINK_EN
    // Find a phase boundary, then the mask must hold 8 cycles and toggle.
    seen_mask = blink_mask;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (blink_mask !== seen_mask) found = 1'b1;
    end
    check("blink_toggle_seen", 32'(found), 32'd1);
    first_mask = blink_mask;
    check("blink_first_legal", 32'((first_mask == 8'h04) || (first_mask == 8'h00)), 32'd1);
    for (int k = 0; k < 24; k++) begin
      check("blink_pattern", 32'(blink_mask),
            32'((((k / 8) % 2) == 0) ? first_mask : (first_mask ^ 8'h04)));
      @(negedge clk);
    end

    // A left press forces the visible phase, then blinking resumes on digit 3.
    @(negedge clk);
    expect_press(M_LEFT);
    btn   = M_LEFT;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cursor === 3'd3) found = 1'b1;
    end
    check("blink_left_seen", 32'(found), 32'd1);
    for (int k = 0; k < 16; k++) begin
      check("blink_after_edit", 32'(blink_mask), (k < 8) ? 32'h00 : 32'h08);
      @(negedge clk);
    end
    btn = '0;
    repeat (10) @(negedge clk);
`else
    press(M_LEFT);
`endif
    check("final_cursor", 32'(cursor), 32'd3);
    check("final_data_out", data_out, 32'h0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_entry_pad.md
Name: hex_entry_pad

Overview:
- Input-side counterpart of the 8-digit seven-segment display path: turns board push-buttons into a 32-bit hex value, one nibble per display digit.
- The display side renders `data_out`, and optionally blinks the digit under edit.
- Sits between the raw board buttons and whatever consumes `commit_data`, e.g. the CPU's I/O register or a display mux.
- Five buttons: up/down edit the selected nibble, left/right move the cursor, center commits.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new button level (10 ms at 100 MHz); minimum 2.
- BLINK_HALF, 25000000, cycles per blink half-period; only used with HEX_ENTRY_BLINK_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_up  input  1  raw button, active-high, asynchronous to clk
- btn_down  input  1  raw button
- btn_left  input  1  raw button
- btn_right  input  1  raw button
- btn_center  input  1  raw button
- data_out  output  32  working value being edited, nibble i = display digit i
- cursor  output  3  index of the selected nibble, 0 = LSB digit
- commit  output  1  one-cycle pulse when `commit_data` updates
- commit_data  output  32  last committed value
- blink_mask  output  8  per-digit blank request, 1 = blank digit (HEX_ENTRY_BLINK_EN only)

Behaviour:
- Reset (async assert, sync release) sets these values:
  - `data_out` = 0, `commit_data` = 0, `cursor` = 0, `commit` = 0, `blink_mask` = 0.
  - All synchronizers and debounced levels = 0, all counters = 0.
- Reset mid-debounce or mid-blink discards all progress.
- Synchronizer: each button passes through a 2-flop synchronizer.
- Debouncer, per button, 4 states:
  - S0 (stable low) -> W1 when sync=1. Counter cleared.
  - W1 -> S1 when the counter reaches DEBOUNCE_CYCLES-1 with sync still 1.
  - W1 -> S0 immediately if sync=0. Counter cleared.
  - S1 (stable high) -> W0 when sync=0.
  - W0 -> S0 when the counter reaches DEBOUNCE_CYCLES-1 with sync still 0.
  - W0 -> S1 if sync=1 again.
  - Counter width is clog2(DEBOUNCE_CYCLES). Debounced level = 1 in S1 and W0.
- Press pulse:
  - One-cycle pulse on the W1->S1 transition only.
  - A held button produces exactly one pulse; there is no auto-repeat.
  - Release generates nothing.
- Action: the cycle after the pulse, registers update.
  - up: nibble[cursor] <= nibble+1 mod 16 (F -> 0); other nibbles unchanged.
  - down: nibble[cursor] <= nibble-1 mod 16 (0 -> F).
  - left: cursor <= cursor+1 mod 8 (7 -> 0).
  - right: cursor <= cursor-1 mod 8 (0 -> 7).
  - center: `commit_data` <= `data_out`, and `commit` = 1 for exactly that one cycle. `data_out` and `cursor` are unchanged.
- Latency: raw edge -> `data_out`/`cursor`/`commit` change = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. The bench checks within ±1 cycle.
- Simultaneous pulses in the same cycle: only the highest priority acts; the others are dropped, not queued.
  - Priority order: center > up > down > left > right.
- Glitches shorter than DEBOUNCE_CYCLES never produce a pulse.

Optional Feature:
- Macro: HEX_ENTRY_BLINK_EN.
- Defined:
  - A free-running counter toggles a phase bit every BLINK_HALF cycles.
  - `blink_mask` = one-hot(cursor) when phase = 1, else 0.
  - Any accepted up/down/left/right action clears the counter and forces phase = 0, so the edited digit is visible immediately.
- Not defined:
  - `blink_mask` port is still present and tied to 8'h00.
  - No blink counter is synthesized.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_HALF=8):
- Reset, then idle 50 cycles -> `data_out`=0, `cursor`=0, `commit` never asserts.
- Press up 3 times (hold 10 cycles, release 10 cycles each) -> `data_out`=32'h00000003; then down 4 times -> 32'h0000000F (wrap).
- Press left 9 times -> `cursor`=1 (wrap via 7->0); press up -> `data_out`=32'h0000001F; press right twice -> `cursor`=7.
- Glitch: btn_up high for 2 cycles, 5 times -> no change. Hold btn_up 200 cycles -> exactly one increment.
- up and center rise in the same cycle with `data_out`=32'h0000001F -> `commit` pulses once, `commit_data`=32'h0000001F, `data_out` unchanged (up dropped). Assert rst_n mid-W1 -> all outputs 0, no pulse after release.
- With HEX_ENTRY_BLINK_EN, `cursor`=2 -> `blink_mask` alternates 8'h04/8'h00 every 8 cycles. A press of left forces 8'h00, then blinking resumes on 8'h08. Without the macro -> `blink_mask` constantly 8'h00.
